multicycle_control: RTL and testbench

Moore-style main controller that sequences the shared multicycle RV32I datapath: one memory port, one ALU, the PC, IR, ALUOut and register-file write enables. It walks every instruction through fetch, decode, execute, memory and writeback states and drives the datapath strobes for each cycle. It replaces the single-cycle opcode decoder when the core is built multicycle. It covers the same instruction classes: R-type, load, store and branch.

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main controller for the shared multicycle RV32I
// datapath. It sequences fetch, decode, execute, memory and writeback for
// R-type, load, store and branch instructions. Unsupported opcodes trap
// until reset.
// Optional build macro MEM_WAIT_EN adds the mem_ready port. FETCH, MEMREAD
// and MEMWRITE then stall until memory completes.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Datapath strobe bundle, built in one place and masked once during reset.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [6:0] op_q;
  logic       rdy;
  ctrl_t      ctl, ctl_o;

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // State register. The opcode is captured in DECODE so that MEMADR can
  // choose between load and store after IR contents move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next-state and per-state strobe decode. The only live input is opcode
  // in DECODE, plus the mem_ready handshake when wait states are built in.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = rdy;
        ctl.pc_write  = rdy;
        ctl.alu_src_b = 2'b01;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // The branch target is computed early into ALUOut.
        ctl.alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d = (op_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 1'b1;
        ctl.instr_done    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        // TRAP is a dead end; only reset leaves it, so illegal stays sticky.
        ctl.illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Every output, including the debug state, reads zero while reset is held.
  assign ctl_o = rst_n ? ctl : '0;
  assign state = rst_n ? state_q : 4'd0;

  assign PCWrite     = ctl_o.pc_write;
  assign PCWriteCond = ctl_o.pc_write_cond;
  assign PCSource    = ctl_o.pc_source;
  assign IorD        = ctl_o.iord;
  assign MemRead     = ctl_o.mem_read;
  assign MemWrite    = ctl_o.mem_write;
  assign IRWrite     = ctl_o.ir_write;
  assign MemtoReg    = ctl_o.mem_to_reg;
  assign RegWrite    = ctl_o.reg_write;
  assign ALUSrcA     = ctl_o.alu_src_a;
  assign ALUSrcB     = ctl_o.alu_src_b;
  assign ALUOp       = ctl_o.alu_op;
  assign illegal     = ctl_o.illegal;
  assign instr_done  = ctl_o.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed cycle-by-cycle bench. Each step pushes the
// expected output vector for the cycle into a scoreboard queue. The vector
// is popped and compared at the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegWrite, ALUSrcA, illegal, instr_done;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;

  logic [19:0] sb_q[$];
  string       tag_q[$];

  // Clock generation.
  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
`ifdef MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .illegal     (illegal),
    .instr_done  (instr_done),
    .state       (state)
  );

  wire [19:0] obs = {state, PCWrite, PCWriteCond, PCSource, IorD, MemRead,
                     MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, ALUOp, illegal, instr_done};

  // Reference output table for a given state.
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic rdy);
    logic pcw, pcc, pcs, iord, mr, mw, irw, m2r, rw, asa, ill, done;
    logic [1:0] asb, aop;
    {pcw, pcc, pcs, iord, mr, mw, irw, m2r, rw, asa, ill, done} = '0;
    asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0: begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
      4'd1: asb = 2'b10;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mr = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; done = 1; end
      4'd5: begin mw = 1; iord = 1; done = rdy; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; done = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 1; done = 1; end
      4'd9: ill = 1;
      default: ;
    endcase
    return {st, pcw, pcc, pcs, iord, mr, mw, irw, m2r, rw, asa, asb, aop, ill, done};
  endfunction

  task automatic check_front();
    logic [19:0] e;
    string t;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: got empty queue want one entry");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: got %h want %h", t, obs, e);
      end
    end
  endtask

  // One normal cycle: drive opcode, expect state st, and step to the next cycle.
  task automatic cyc(input logic [6:0] op, input logic [3:0] st, input string tag);
    opcode = op;
    sb_q.push_back(exp_vec(st, mem_ready));
    tag_q.push_back(tag);
    @(negedge clk);
    check_front();
    @(posedge clk); #1;
  endtask

  // One cycle with reset held low: every output must read zero.
  task automatic rst_cyc(input string tag);
    rst_n = 1'b0;
    sb_q.push_back(20'd0);
    tag_q.push_back(tag);
    @(negedge clk);
    check_front();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 7'h00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_cyc("reset");

    // R-type; junk opcodes outside DECODE must have no effect.
    cyc(7'b1111111, 0, "r_fetch");
    cyc(7'b0110011, 1, "r_decode");
    cyc(7'b0000011, 6, "r_exec");
    cyc(7'b1100011, 7, "r_wb");

    // Load; MEMADR sees a store opcode on the bus but must use the latched load.
    cyc(7'b0100011, 0, "ld_fetch");
    cyc(7'b0000011, 1, "ld_decode");
    cyc(7'b0100011, 2, "ld_adr");
    cyc(7'b0100011, 3, "ld_read");
    cyc(7'b0110011, 4, "ld_wb");

    // Store; MEMADR sees a load opcode on the bus.
    cyc(7'b0000011, 0, "st_fetch");
    cyc(7'b0100011, 1, "st_decode");
    cyc(7'b0000011, 2, "st_adr");
    cyc(7'b1111111, 5, "st_write");

    // Branch.
    cyc(7'b0110011, 0, "br_fetch");
    cyc(7'b1100011, 1, "br_decode");
    cyc(7'b0000000, 8, "br_branch");

    // Reset asserted mid-cycle inside a load.
    cyc(7'b0000000, 0, "mid_fetch");
    cyc(7'b0000011, 1, "mid_decode");
    cyc(7'b0000000, 2, "mid_adr");
    #2 rst_cyc("mid_reset");
    cyc(7'b0000000, 0, "post_fetch");
    cyc(7'b0110011, 1, "post_decode");
    cyc(7'b0000000, 6, "post_exec");
    cyc(7'b0000000, 7, "post_wb");
    cyc(7'b0000000, 0, "post_next");

    // Illegal opcode traps and holds for 20 cycles.
    cyc(7'b1111111, 1, "ill_decode");
    for (int i = 0; i < 20; i++) cyc(7'($urandom), 9, "ill_trap");
    rst_cyc("ill_reset");
    cyc(7'b0000000, 0, "ill_fetch");

    // A legal-looking but unsupported class (I-type ALU) also traps.
    cyc(7'b0010011, 1, "itype_decode");
    cyc(7'b0110011, 9, "itype_trap");
    cyc(7'b1100011, 9, "itype_trap2");
    rst_cyc("itype_reset");
    cyc(7'b0000000, 0, "itype_fetch");
    cyc(7'b1100011, 1, "itype_br_decode");
    cyc(7'b0000000, 8, "itype_br");

`ifdef MEM_WAIT_EN
    // FETCH stalls for three cycles, then completes.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(7'b0, 0, "w_fetch_stall");
    mem_ready = 1'b1;
    cyc(7'b0, 0, "w_fetch_go");
    cyc(7'b0000011, 1, "w_ld_decode");
    cyc(7'b0, 2, "w_ld_adr");
    mem_ready = 1'b0;
    cyc(7'b0, 3, "w_ld_stall1");
    cyc(7'b0, 3, "w_ld_stall2");
    mem_ready = 1'b1;
    cyc(7'b0, 3, "w_ld_read");
    cyc(7'b0, 4, "w_ld_wb");
    // Store with one wait cycle in MEMWRITE.
    cyc(7'b0, 0, "w_st_fetch");
    cyc(7'b0100011, 1, "w_st_decode");
    cyc(7'b0, 2, "w_st_adr");
    mem_ready = 1'b0;
    cyc(7'b0, 5, "w_st_stall");
    mem_ready = 1'b1;
    cyc(7'b0, 5, "w_st_write");
    cyc(7'b0, 0, "w_st_next");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
